// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code width and bitwise op encodings.
// The arithmetic units import the same package.
package alu_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
   localparam logic [OP_W-1:0] OP_AND  = 3'd1;
   localparam logic [OP_W-1:0] OP_OR   = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
   localparam logic [OP_W-1:0] OP_NAND = 3'd4;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
   localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/bitwise_core.sv
// Combinational bitwise datapath: result plus zero/ones/parity flags.
module bitwise_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ones,
   output logic             parity
);

   // operation select; b is unused by NOT and PASS
   always_comb begin
      y = '0;
      case (op)
         OP_NOT:  y = ~a;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_PASS: y = a;
         default: y = '0;
      endcase
   end

   // flags are derived from the result, so they travel with it into the buffer
   always_comb begin
      zero   = ~|y;
      ones   = &y;
      parity = ^y;
   end

endmodule

// File: rtl/bitwise_unit.sv
// Registered bitwise unit: valid/ready operand input, 2-entry result FIFO
// holding result and flags, valid/ready result output.
module bitwise_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_ones,
   output logic             out_parity,
   output logic [1:0]       out_count
);

   logic [WIDTH-1:0]            core_y;
   logic                        core_zero, core_ones, core_parity;

   logic [DEPTH-1:0][WIDTH-1:0] buf_y;
   logic [DEPTH-1:0]            buf_zero, buf_ones, buf_parity;
   logic                        wr_ptr, rd_ptr;
   logic [1:0]                  count;
   logic                        push, pop;

   bitwise_core #(.WIDTH(WIDTH)) u_core (
      .op     (in_op),
      .a      (in_a),
      .b      (in_b),
      .y      (core_y),
      .zero   (core_zero),
      .ones   (core_ones),
      .parity (core_parity)
   );

   // handshake: ready comes only from registered occupancy, never from out_ready
   always_comb begin
      in_ready  = (count < 2'(DEPTH));
      out_valid = (count != 2'd0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      out_count = count;
   end

   // head entry on the output; forced to zero when empty so stale data never shows
   always_comb begin
      out_y      = '0;
      out_zero   = 1'b0;
      out_ones   = 1'b0;
      out_parity = 1'b0;
      if (out_valid) begin
         out_y      = buf_y[rd_ptr];
         out_zero   = buf_zero[rd_ptr];
         out_ones   = buf_ones[rd_ptr];
         out_parity = buf_parity[rd_ptr];
      end
   end

   // buffer write only on accept, so idle X on op/a/b never lands in storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_y      <= '0;
         buf_zero   <= '0;
         buf_ones   <= '0;
         buf_parity <= '0;
         wr_ptr     <= 1'b0;
      end else if (push) begin
         buf_y[wr_ptr]      <= core_y;
         buf_zero[wr_ptr]   <= core_zero;
         buf_ones[wr_ptr]   <= core_ones;
         buf_parity[wr_ptr] <= core_parity;
         wr_ptr             <= ~wr_ptr;
      end
   end

   // read pointer and occupancy; push+pop together leaves count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/bitwise_unit.md
Name: bitwise_unit

Overview:
Parametrised, registered bitwise logic unit for the integer ALU. It supersedes the single-bit combinational inverter with a WIDTH-bit datapath, eight bitwise operations and result flags. Operands enter through a valid/ready handshake. Results leave through a 2-entry output buffer with valid/ready, so the block sits between the ALU decode stage and the writeback/result mux.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..64)
DEPTH, 2, output buffer entries (fixed at 2; the parameter exists only so benches can check it)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept an operand beat
in_op  input  3  operation code (see Behaviour)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (ignored for NOT and PASS)
out_valid  output  1  head result valid
out_ready  input  1  consumer accepts head result
out_y  output  WIDTH  result of the head entry
out_zero  output  1  head result is all zeros
out_ones  output  1  head result is all ones
out_parity  output  1  XOR-reduction of the head result
out_count  output  2  current buffer occupancy (0..2)

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Op codes: 0 NOT a; 1 a AND b; 2 a OR b; 3 a XOR b; 4 NAND; 5 NOR; 6 XNOR; 7 PASS a.
- Result and flags are computed combinationally from in_op, in_a and in_b. They are written into the buffer on accept (in_valid && in_ready). Flags are stored with the result, not recomputed at the output.
- Reset, asynchronous: count=0, read/write pointers=0, out_valid=0, out_y=0, all flags=0, out_count=0. Reset asserted mid-operation discards all buffered entries at once. No output glitches high during reset.
- in_ready = (count < 2). It depends on registered state only; there is no combinational path from out_ready to in_ready.
- out_valid = (count > 0). out_y and the flags show the head entry. When empty they are driven to 0.
- Latency: an accepted beat appears on out_valid at the next rising edge when the buffer was empty. There is no bypass on the same cycle.
- Pop: on out_valid && out_ready, the head advances at the clock edge.
- Simultaneous push and pop at count=1: count stays 1, the new entry becomes the head after the old head pops, and order is preserved.
- Count=2: in_ready=0. A pop frees one slot, and in_ready rises in the following cycle.
- Count=0 with out_ready=1: no pop and no underflow. Count stays 0.
- Pointers wrap modulo 2.
- in_op, in_a and in_b are don't-care when in_valid=0. An X on these while idle must not propagate into the buffer.
- Results are strictly FIFO order. No entry is dropped or duplicated.

Decomposition:
- Shared package alu_pkg holds the 3-bit op-code localparams (OP_NOT..OP_PASS) and the op-width constant OP_W=3. The future arithmetic units reuse it.
- One sub-module, bitwise_core: combinational, parametrised WIDTH. Inputs are op, a and b; outputs are y, zero, ones and parity.
- The handshake, buffer and pointers stay in bitwise_unit.

Test Plan:
1. Reset: hold rst_n=0 with random inputs, release -> out_valid=0, out_y=0, in_ready=1, out_count=0. Assert rst_n=0 while count=2 -> outputs clear immediately without waiting for a clock edge.
2. Op sweep, WIDTH=8, a=8'hA5, b=8'h0F, out_ready=1:
   - NOT -> 8'h5A
   - AND -> 8'h05
   - OR -> 8'hAF
   - XOR -> 8'hAA
   - NAND -> 8'hFA
   - NOR -> 8'h50
   - XNOR -> 8'h55
   - PASS -> 8'hA5
   - Each result arrives one cycle after accept, with correct parity (e.g. 8'h5A -> 0).
3. Flags:
   - a=8'hFF, b=8'hFF, AND -> out_y=8'hFF, out_ones=1, out_zero=0, out_parity=0.
   - a=8'hFF, NOT -> out_y=8'h00, out_zero=1.
4. Backpressure: out_ready=0, push 3 beats -> in_ready=0 after the 2nd beat and out_count=2. The 3rd beat stalls until one pop. Then set out_ready=1 -> results drain in order with no loss.
5. Simultaneous push/pop at count=1 for 20 cycles with a streaming counter pattern -> out_count stays 1 and the output sequence equals the input sequence delayed by one entry.
6. Width sweep: WIDTH=1 reproduces the inverter truth table (NOT 0 -> 1, NOT 1 -> 0). WIDTH=32 with a=32'h0000_0000, NOT -> 32'hFFFF_FFFF and out_ones=1.
